// File: rtl/lu_opid_pkg.sv
// Shared types and constants for the LU operation identifier.
// Holds the FSM state encoding, the select-code constants, the truth table
// of the four candidate operations and two small mask helper functions.
package lu_opid_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2,
    ERROR   = 2'd3
  } state_t;

  localparam logic [1:0] OP_XNOR = 2'b00;
  localparam logic [1:0] OP_XOR  = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [1:0] OP_NOR  = 2'b11;

  // OP_TABLE[k][{a,b}] is the result of operation k for operands a,b.
  // Row order follows the select code: XNOR, XOR, OR, NOR.
  localparam logic [3:0][3:0] OP_TABLE = {
    4'b0001,  // NOR  : only 00 gives 1
    4'b1110,  // OR   : everything but 00 gives 1
    4'b0110,  // XOR  : 01 and 10 give 1
    4'b1001   // XNOR : 00 and 11 give 1
  };

  localparam int CNT_W = 4;

  function automatic logic is_one_hot(input logic [3:0] m);
    return (m != 4'd0) && ((m & (m - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] lowest_index(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lu_opid_compat.sv
// Combinational compatibility check: bit k of compat is set when operation k
// applied to (a,b) reproduces the observed result s.
module lu_opid_compat
  import lu_opid_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       s,
  output logic [3:0] compat
);

  // Look up each candidate's result for this operand pair and compare with s
  always_comb begin
    compat = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      compat[k] = (OP_TABLE[k][{a, b}] == s);
    end
  end

endmodule

// File: rtl/lu_op_identifier.sv
// LU operation identifier: narrows four candidate operations down using
// observed (a, b, s) samples until one remains or the sample budget runs out.
// Optional feature macro LU_OPID_CONFLICT_EN adds an err output and an ERROR
// state entered when no candidate survives; without it such a run falls back
// to IDLE with an all-zero candidate mask.
module lu_op_identifier
  import lu_opid_pkg::*;
#(
  parameter int MAX_SAMPLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       a,
  input  logic       b,
  input  logic       s,
  output logic       op_valid,
  input  logic       op_ack,
  output logic [1:0] op_code,
  output logic       ambiguous,
  output logic [3:0] cand_mask,
`ifdef LU_OPID_CONFLICT_EN
  output logic       busy,
  output logic       err
`else
  output logic       busy
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SAMPLES);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic [3:0]       compat;
  logic [3:0]       merged_mask;
  logic             accept;
  logic             merged_unique;
  logic             merged_zero;
  logic             budget_spent;

  lu_opid_compat u_compat (
    .a      (a),
    .b      (b),
    .s      (s),
    .compat (compat)
  );

  assign accept        = in_valid && in_ready;
  assign merged_mask   = cand_mask & compat;
  assign count_inc     = count + 1'b1;
  assign merged_unique = is_one_hot(merged_mask);
  assign merged_zero   = (merged_mask == 4'b0000);
  assign budget_spent  = (count_inc == MAX_CNT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; start restarts a run from COLLECT and ERROR, but not DONE
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = COLLECT;
      end
      COLLECT: begin
        if (start) begin
          state_next = COLLECT;
        end else if (accept) begin
          if (merged_zero) begin
`ifdef LU_OPID_CONFLICT_EN
            state_next = ERROR;
`else
            state_next = IDLE;
`endif
          end else if (merged_unique || budget_spent) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (op_ack) state_next = IDLE;
      end
      ERROR: begin
`ifdef LU_OPID_CONFLICT_EN
        if (start) state_next = COLLECT;
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Candidate mask, sample count and result registers; results are latched
  // on the deciding acceptance so they are stable for the whole DONE state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_mask <= 4'b1111;
      count     <= '0;
      op_code   <= OP_XNOR;
      ambiguous <= 1'b0;
    end else begin
      case (state)
        IDLE, ERROR: begin
          if (start) begin
            cand_mask <= 4'b1111;
            count     <= '0;
            op_code   <= OP_XNOR;
            ambiguous <= 1'b0;
          end
        end
        COLLECT: begin
          if (start) begin
            cand_mask <= 4'b1111;
            count     <= '0;
          end else if (accept) begin
            cand_mask <= merged_mask;
            count     <= count_inc;
            if (merged_unique) begin
              op_code   <= lowest_index(merged_mask);
              ambiguous <= 1'b0;
            end else if (!merged_zero && budget_spent) begin
              op_code   <= lowest_index(merged_mask);
              ambiguous <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs decoded from the current state
  always_comb begin
    op_valid = (state == DONE);
    busy     = (state == COLLECT);
    in_ready = (state == COLLECT) && !start;
`ifdef LU_OPID_CONFLICT_EN
    err      = (state == ERROR);
`endif
  end

endmodule

// File: tb/tb_lu_op_identifier.sv
// Self-checking bench for lu_op_identifier (MAX_SAMPLES = 2).
// Expected results are queued when a run is issued; a negedge monitor pops
// and compares them when op_valid rises and checks they stay stable in DONE.
module tb_lu_op_identifier;

  typedef struct {
    logic [1:0] code;
    logic       amb;
    logic [3:0] mask;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic       a;
  logic       b;
  logic       s;
  logic       op_valid;
  logic       op_ack;
  logic [1:0] op_code;
  logic       ambiguous;
  logic [3:0] cand_mask;
  logic       busy;
`ifdef LU_OPID_CONFLICT_EN
  logic       err;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t held;
  logic seen = 1'b0;
  logic held_ok = 1'b0;

  lu_op_identifier #(.MAX_SAMPLES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .s         (s),
    .op_valid  (op_valid),
    .op_ack    (op_ack),
    .op_code   (op_code),
    .ambiguous (ambiguous),
    .cand_mask (cand_mask),
`ifdef LU_OPID_CONFLICT_EN
    .err       (err),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Offer one sample and hold it until it is accepted (bounded wait)
  task automatic applyStimulus(input logic sa, input logic sb_in, input logic ss);
    bit ok;
    ok = 1'b0;
    a = sa; b = sb_in; s = ss; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0 expected 1 at %0t", $time);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic startRun();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic ackResult();
    op_ack = 1'b1;
    @(posedge clk);
    #1 op_ack = 1'b0;
    checkOutput("op_valid_after_ack", op_valid, 0);
  endtask

  task automatic pushExp(input logic [1:0] code, input logic amb, input logic [3:0] mask);
    exp_t e;
    e.code = code; e.amb = amb; e.mask = mask;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: pop on op_valid rising, then check stability in DONE
  always @(negedge clk) begin
    if (!rst_n || !op_valid) begin
      seen = 1'b0;
    end else if (!seen) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        held_ok = 1'b0;
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: op_valid=1 with no queued expectation at %0t", $time);
      end else begin
        held = sb.pop_front();
        held_ok = 1'b1;
        checkOutput("sb_op_code", op_code, held.code);
        checkOutput("sb_ambiguous", ambiguous, held.amb);
        checkOutput("sb_cand_mask", cand_mask, held.mask);
      end
    end else if (held_ok) begin
      checkOutput("hold_op_code", op_code, held.code);
      checkOutput("hold_ambiguous", ambiguous, held.amb);
      checkOutput("hold_cand_mask", cand_mask, held.mask);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; op_ack = 1'b0;
    a = 1'b0; b = 1'b0; s = 1'b0;
    #12;
    checkOutput("rst_op_valid", op_valid, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cand_mask", cand_mask, 4'b1111);
    checkOutput("rst_op_code", op_code, 2'b00);
    checkOutput("rst_ambiguous", ambiguous, 0);
`ifdef LU_OPID_CONFLICT_EN
    checkOutput("rst_err", err, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // NOR: (0,0,1) leaves XNOR/NOR, (1,1,0) leaves NOR only
    pushExp(2'b11, 1'b0, 4'b1000);
    startRun();
    checkOutput("collect_busy", busy, 1);
    checkOutput("collect_mask", cand_mask, 4'b1111);
    applyStimulus(0, 0, 1);
    checkOutput("nor_mid_mask", cand_mask, 4'b1001);
    checkOutput("nor_mid_valid", op_valid, 0);
    applyStimulus(1, 1, 0);
    checkOutput("nor_valid_latency", op_valid, 1);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("done_start_ignored_valid", op_valid, 1);
    checkOutput("done_start_ignored_busy", busy, 0);
    checkOutput("done_in_ready", in_ready, 0);
    ackResult();
    checkOutput("idle_busy", busy, 0);

    // OR: (0,0,0) -> 0110, (1,1,1) -> 0100
    pushExp(2'b10, 1'b0, 4'b0100);
    startRun();
    applyStimulus(0, 0, 0);
    applyStimulus(1, 1, 1);
    checkOutput("or_valid", op_valid, 1);
    ackResult();

    // XOR: (0,1,1) -> 0110, (1,1,0) -> 0010
    pushExp(2'b01, 1'b0, 4'b0010);
    startRun();
    applyStimulus(0, 1, 1);
    applyStimulus(1, 1, 0);
    ackResult();

    // Budget of two samples exhausted with XOR/OR both alive
    pushExp(2'b01, 1'b1, 4'b0110);
    startRun();
    applyStimulus(0, 1, 1);
    applyStimulus(1, 0, 1);
    checkOutput("amb_valid", op_valid, 1);
    ackResult();

    // Repeated identical samples still count toward the budget
    pushExp(2'b01, 1'b1, 4'b0110);
    startRun();
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    ackResult();

    // op_ack while idle has no effect
    op_ack = 1'b1;
    @(posedge clk); #1;
    op_ack = 1'b0;
    checkOutput("idle_ack_valid", op_valid, 0);
    checkOutput("idle_ack_busy", busy, 0);

    // Conflict: (0,0,1) -> 1001, (0,0,0) -> 0110, intersection empty
    startRun();
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("conflict_mask", cand_mask, 4'b0000);
    checkOutput("conflict_in_ready", in_ready, 0);
    checkOutput("conflict_valid", op_valid, 0);
    checkOutput("conflict_busy", busy, 0);
`ifdef LU_OPID_CONFLICT_EN
    checkOutput("conflict_err", err, 1);
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput("conflict_mask_held", cand_mask, 4'b0000);
    startRun();
    checkOutput("conflict_restart_busy", busy, 1);
    checkOutput("conflict_restart_mask", cand_mask, 4'b1111);
`ifdef LU_OPID_CONFLICT_EN
    checkOutput("conflict_restart_err", err, 0);
`endif

    // Restart while collecting; the same-cycle sample is not taken
    applyStimulus(0, 0, 1);
    checkOutput("restart_pre_mask", cand_mask, 4'b1001);
    start = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b1; s = 1'b0;
    @(negedge clk);
    checkOutput("restart_in_ready", in_ready, 0);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    checkOutput("restart_mask", cand_mask, 4'b1111);
    checkOutput("restart_busy", busy, 1);
    pushExp(2'b11, 1'b0, 4'b1000);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 1, 0);
    ackResult();

    // Asynchronous reset in the middle of a run
    startRun();
    applyStimulus(0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_in_ready", in_ready, 0);
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_mask", cand_mask, 4'b1111);
    checkOutput("async_rst_valid", op_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lu_op_identifier.md
LU_OP_IDENTIFIER -- requirements
Module: lu_op_identifier

Interface
- REQ-001 SHALL have parameter MAX_SAMPLES, default 8, meaning the maximum accepted samples per identification run (range 2..15).
- REQ-002 SHALL have port clk, input, 1, the single clock (rising edge).
- REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
- REQ-004 SHALL have port start, input, 1, a single-cycle pulse that begins a run.
- REQ-005 SHALL have port in_valid, input, 1, meaning a sample is offered.
- REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts the sample this cycle.
- REQ-007 SHALL have ports a, b and s, inputs, 1 each: LU operands and the observed LU result.
- REQ-008 SHALL have port op_valid, output, 1, meaning the result is held.
- REQ-009 SHALL have port op_ack, input, 1, meaning the consumer takes the result.
- REQ-010 SHALL have port op_code, output, 2, the identified select code: 00 XNOR, 01 XOR, 10 OR, 11 NOR.
- REQ-011 SHALL have port ambiguous, output, 1, meaning more than one candidate remains.
- REQ-012 SHALL have port cand_mask, output, 4, with bit k set while op code k is still consistent.
- REQ-013 SHALL have port busy, output, 1, high in COLLECT.

Function
- REQ-014 SHALL implement states IDLE, COLLECT, DONE (plus ERROR, see Configuration).
- REQ-015 SHALL, in IDLE on start, load cand_mask=1111, clear the sample count and enter COLLECT.
- REQ-016 SHALL drive in_ready = (state==COLLECT) && !start; a sample is accepted when in_valid && in_ready.
- REQ-017 SHALL, on acceptance, set cand_mask <= cand_mask & compat(a,b,s), where compat bit k = (op_k(a,b)==s), and increment the count.
- REQ-018 SHALL enter DONE when the new mask has exactly one bit set: op_valid=1, op_code=index of that bit, ambiguous=0, with results visible the cycle after acceptance.
- REQ-019 SHALL enter DONE with ambiguous=1 and op_code=lowest set bit when the count reaches MAX_SAMPLES with more than one bit still set.
- REQ-020 SHALL treat a zero mask after acceptance as a conflict (see Configuration).
- REQ-021 SHALL hold op_valid, op_code, ambiguous and cand_mask stable in DONE until op_ack, then return to IDLE; op_valid deasserts the cycle after op_ack.
- REQ-022 SHALL, on start in COLLECT, restart the run (mask=1111, count=0); the same-cycle sample is not accepted.
- REQ-023 SHALL ignore start in DONE; op_ack outside DONE has no effect.
- REQ-024 SHALL count repeated identical samples as accepted; the mask is unchanged by them.

Reset
- REQ-025 SHALL, on rst_n low, immediately set state=IDLE, cand_mask=1111, count=0, op_valid=0, op_code=00, ambiguous=0, busy=0 and in_ready=0, including mid-run.

Configuration
- REQ-026 SHALL, with LU_OPID_CONFLICT_EN defined, add output err (1 bit, reset 0) and on a zero mask enter ERROR with err=1 and in_ready=0 until start, which clears err and begins a new run.
- REQ-027 SHALL, without LU_OPID_CONFLICT_EN, have no err port; a zero mask returns to IDLE with op_valid=0 and cand_mask=0000 held until the next start.

Structure
- REQ-028 SHALL place the state enum, the op code constants (XNOR/XOR/OR/NOR) and the 4x4 truth-table constant in package lu_opid_pkg.
- REQ-029 SHALL implement compat() as combinational sub-module lu_opid_compat (inputs a, b, s; output 4-bit mask).

Verification
- REQ-030 SHALL cover: start; samples (0,0,s=1) then (1,1,s=0) -> op_valid with op_code=11, ambiguous=0, op_valid one cycle after the second acceptance.
- REQ-031 SHALL cover: samples (0,0,0), (1,1,1) -> op_code=10; samples (0,1,1), (1,1,0) -> op_code=01.
- REQ-032 SHALL cover: MAX_SAMPLES=2; samples (0,1,1), (1,0,1) -> ambiguous=1, cand_mask=0110, op_code=01.
- REQ-033 SHALL cover: samples (0,0,1), (0,0,0) -> with the macro, err=1 and in_ready=0; without it, IDLE with cand_mask=0000.
- REQ-034 SHALL cover: start asserted with in_valid in COLLECT -> in_ready=0 and mask=1111; rst_n low mid-run -> all outputs at reset values asynchronously.
- REQ-035 SHALL cover: DONE held for 3 cycles without op_ack -> outputs stable and start ignored; op_ack -> IDLE the next cycle.
